// File: rtl/block_checker.sv
// Streaming begin/end nesting checker: one ASCII byte per clock, result high while balanced.
// Optional BLOCK_CHECKER_CASE_FOLD_EN makes keyword letters case-insensitive.
module block_checker #(
    parameter int DEPTH_W = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in,
    output logic       result
);

    typedef enum logic [3:0] {
        S_IDLE, S_B, S_BE, S_BEG, S_BEGI, S_BEGIN, S_E, S_EN, S_END, S_OTHER
    } state_t;

    state_t                     state, state_nx;
    logic signed [DEPTH_W-1:0]  depth;
    logic                       broken;
    logic                       inc, dec, set_broken;
    logic [7:0]                 ch;
    logic                       is_space;

    function automatic logic [7:0] fold_char(input logic [7:0] c);
`ifdef BLOCK_CHECKER_CASE_FOLD_EN
        return c | 8'h20;
`else
        return c;
`endif
    endfunction

    // Space detection uses the raw byte so 8'h00 cannot fold into a separator
    assign ch       = fold_char(in);
    assign is_space = (in == 8'h20);

    always_comb begin
        state_nx   = S_OTHER;
        inc        = 1'b0;
        dec        = 1'b0;
        set_broken = 1'b0;
        if (is_space) begin
            state_nx   = S_IDLE;
            set_broken = (state == S_END) && (depth < 0);
        end else begin
            case (state)
                S_IDLE:  state_nx = (ch == "b") ? S_B : (ch == "e") ? S_E : S_OTHER;
                S_B:     state_nx = (ch == "e") ? S_BE   : S_OTHER;
                S_BE:    state_nx = (ch == "g") ? S_BEG  : S_OTHER;
                S_BEG:   state_nx = (ch == "i") ? S_BEGI : S_OTHER;
                S_BEGI: begin
                    state_nx = (ch == "n") ? S_BEGIN : S_OTHER;
                    inc      = (ch == "n");
                end
                S_E:     state_nx = (ch == "n") ? S_EN : S_OTHER;
                S_EN: begin
                    state_nx = (ch == "d") ? S_END : S_OTHER;
                    dec      = (ch == "d");
                end
                // A letter after a completed keyword reverts its tentative count
                S_BEGIN: dec = 1'b1;
                S_END:   inc = 1'b1;
                default: state_nx = S_OTHER;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            depth  <= '0;
            broken <= 1'b0;
        end else begin
            state <= state_nx;
            if (inc)
                depth <= depth + DEPTH_W'(1);
            else if (dec)
                depth <= depth - DEPTH_W'(1);
            if (set_broken)
                broken <= 1'b1;
        end
    end

    assign result = !broken && (depth == '0);

endmodule

// File: tb/tb_block_checker.sv
// Directed test-plan sequences plus random word streams, checked against a word-level model.
module tb_block_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in;
    logic       result;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] word[$];
    int         cdepth;
    bit         mbroken;

    block_checker #(.DEPTH_W(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .in     (in),
        .result (result)
    );

    always #5 clk = ~clk;

`ifdef BLOCK_CHECKER_CASE_FOLD_EN
    localparam string KW_B = "BEGiN";
    localparam string KW_E = "End";
`else
    localparam string KW_B = "begin";
    localparam string KW_E = "end";
`endif

    function automatic logic [7:0] mfold(input logic [7:0] c);
`ifdef BLOCK_CHECKER_CASE_FOLD_EN
        return c | 8'h20;
`else
        return c;
`endif
    endfunction

    function automatic bit word_is(input string kw);
        if (word.size() != kw.len()) return 1'b0;
        for (int i = 0; i < kw.len(); i++)
            if (word[i] != kw[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int wdelta();
        if (word_is("begin")) return 1;
        if (word_is("end"))   return -1;
        return 0;
    endfunction

    function automatic bit mexp();
        return !mbroken && ((cdepth + wdelta()) == 0);
    endfunction

    task automatic model_reset();
        word.delete();
        cdepth  = 0;
        mbroken = 1'b0;
    endtask

    task automatic model_char(input logic [7:0] c);
        int d;
        if (c == 8'h20) begin
            d = wdelta();
            cdepth += d;
            if (d < 0 && cdepth < 0) mbroken = 1'b1;
            word.delete();
        end else begin
            word.push_back(mfold(c));
        end
    endtask

    task automatic check(input string tag, input logic expv);
        vectors++;
        assert (result === expv) else begin
            miscompares++;
            $error("FAIL %s: result=%b expected=%b", tag, result, expv);
        end
    endtask

    task automatic step(input logic [7:0] c, input string tag);
        in = c;
        @(posedge clk);
        #1;
        model_char(c);
        check(tag, mexp());
    endtask

    // e holds the literal per-character expected result ('0'/'1'), or is empty
    task automatic send(input string s, input string e, input string tag);
        logic [7:0] c;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            step(c, tag);
            if (e.len() > 0) check({tag, "_lit"}, e[i] == "1");
        end
    endtask

    task automatic async_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check(tag, 1'b1);
        @(negedge clk);
        reset = 1'b0;
    endtask

    string pool[12] = '{"begin", "end", "BEGIN", "End", "eNd", "beginx",
                        "endc", "xend", "be", "en", "b", "e"};

    initial begin
        reset = 1'b1;
        in    = 8'h20;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_value", 1'b1);
        @(negedge clk);
        reset = 1'b0;

        send("    ", "1111", "idle_spaces");
        send({"a ", KW_E, " ", KW_B, " ", KW_E, " ", KW_E, " "},
             "11110000000000000000", "sticky_unmatched");

        send("beg", "", "abandon_word");
        async_reset("async_reset");
        send({KW_B, " ", KW_B, " ", KW_E, " ", KW_E, " "},
             "11110000000000000011", "nested_pair");

        send("beginx ", "1111011", "begin_revert");
        send("endc ", "11011", "end_revert");
        send("end ", "1100", "unmatched_space");
        send("begin end ", "0000000000", "broken_holds");
        async_reset("reset_clears_broken");

`ifdef BLOCK_CHECKER_CASE_FOLD_EN
        send("BEGIN End ", "1111000011", "fold_upper");
`else
        send("BEGIN End ", "1111111111", "nofold_upper");
`endif
        send("begin end ", "1111000011", "lower_pair");

        // Random streams of keywords, near-misses, odd bytes and spaces
        for (int i = 0; i < 800; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 5) begin
                send(pool[$urandom_range(0, 11)], "", "rand_word");
            end else if (r < 8) begin
                step(8'h20, "rand_space");
            end else begin
                step(8'($urandom_range(0, 255)), "rand_byte");
            end
            if ($urandom_range(0, 199) == 0) async_reset("rand_reset");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/block_checker.md
# block_checker

Streaming keyword-nesting checker. It consumes one ASCII character per clock and tracks `begin`/`end` keyword pairing across space-separated words. It drives `result` high while every `begin` seen so far has a matching `end` and no `end` has appeared without an open `begin`. It sits as a standalone checker beside a character source and has no handshake.

## Interface
Parameters:
- `DEPTH_W`, default 32: width of the signed nesting counter.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `in` in 8: ASCII character, sampled every rising edge; no valid strobe.
- `result` out 1: 1 = sequence so far is balanced.

## Operation
- Word parsing:
  - `8'h20` (space) is the only separator.
  - Any other byte is a word character.
  - Consecutive spaces are equivalent to one.
- Keyword match: a word is a keyword only if it is exactly `begin` or `end` (case per Configuration).
  - `beginx`, `ends`, `xend` and `be` are ordinary words.
- Word FSM states: IDLE (after reset or a space), B, BE, BEG, BEGI, BEGIN, E, EN, END, OTHER.
  - IDLE: `b` goes to B, `e` goes to E, space stays in IDLE, any other character goes to OTHER.
  - Each prefix state advances on the next expected letter.
  - A space in any state goes to IDLE.
  - Any other character goes to OTHER.
  - OTHER stays in OTHER until a space.
  - BEGIN or END followed by any non-space goes to OTHER.
- Tentative counting with signed `depth`:
  - Entering BEGIN: `depth` +1.
  - Entering END: `depth` −1.
  - Leaving BEGIN to OTHER (letter follows): `depth` −1 (revert).
  - Leaving END to OTHER: `depth` +1 (revert).
- Sticky error:
  - When END is left via a space and `depth` < 0, set `broken`.
  - `broken` holds until reset.
- `result = !broken && depth == 0`. It is combinational from registers only, with no path from `in`.
- `depth` is not saturated. The nesting limit is the signed range of `DEPTH_W`; overflow behaviour is undefined.

## Timing
- Reset values: state IDLE, `depth` 0, `broken` 0, `result` 1. The empty sequence is balanced.
- Reset is asynchronous. Asserting it mid-word abandons the word. The first character sampled after deassertion starts a fresh word.
- Latency: `result` reflects characters sampled up to and including the most recent rising edge.
  - It updates the same cycle that the final letter of a keyword is sampled.
  - A closing `d` makes `result` valid immediately, without waiting for the trailing space.
- Revert cycle: a letter following a completed keyword restores `depth` on that edge. The output may therefore show a one-cycle transient (e.g. `endx`: 1→0→1).
- `broken` is set on the edge that samples the space after an unmatched `end`. `result` was already 0 from the previous edge.

## Configuration
- `BLOCK_CHECKER_CASE_FOLD_EN`, defined in the default build.
- Defined: letters are compared case-insensitively (`in | 8'h20` against lowercase), so `BEGiN` and `End` are keywords.
- Undefined: only exact lowercase `begin`/`end` match; `End` is an ordinary word.

## Test plan
- Reset then idle spaces → `result` = 1 throughout; `depth` 0.
- `a`, ` `, `End`, ` `, `BEGiN`, ` `, `End`, ` `, `End`, ` ` → `result` falls to 0 on `d` of the first `End`. It stays 0 to the end (sticky), even after the later balanced pair.
- Reset (async, asserted between clock edges) then `BEGiN BEGiN End End ` → `result` is 1 at reset, 0 after the first `N`, and 0 after the first `d` (depth 1). It is 1 after the second `d`, and stays 1 after the trailing space.
- `begin`, `x`, ` ` → `result` 0 after `n`, back to 1 after `x` (revert). It stays 1.
- `endc` → `result` 0 after `d`, 1 after `c`; `broken` is not set. A following ` end ` then sets `broken` on the space.
- Without `BLOCK_CHECKER_CASE_FOLD_EN`: `BEGIN End ` → `result` stays 1; `begin end ` → 0 after `n`, 1 after `d`.
